// File: rtl/pe_mac_bank.sv
// rtl/pe_mac_bank.sv - fixed-point MAC processing element with a bank of accumulator slots
// Two-stage multiply/accumulate pipe plus a rounding/saturating read port with hazard interlock.
module pe_mac_bank #(
  parameter int INT_BITS   = 7,
  parameter int FRAC_BITS  = 9,
  parameter int NUM_ACC    = 8,
  parameter int GUARD_BITS = 4,
  localparam int W = INT_BITS + FRAC_BITS,
  localparam int P = 2 * W,
  localparam int A = P + GUARD_BITS,
  localparam int S = $clog2(NUM_ACC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] data_in_1,
  input  logic signed [W-1:0] data_in_2,
  input  logic        [S-1:0] acc_sel,
  input  logic                acc_init,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic        [S-1:0] rd_sel,
  input  logic                rd_clear,
  input  logic                round_mode,
  input  logic                sat_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic        [W-1:0] data_out,
  output logic                out_ovf
);

  localparam logic signed [A:0] HALF_LSB = (A+1)'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [A:0] MAX_V = {{(A-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [A:0] MIN_V = {{(A-W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

  logic signed [A-1:0] slot [NUM_ACC];

  logic                s1_valid;
  logic signed [P-1:0] s1_prod;
  logic        [S-1:0] s1_sel;
  logic                s1_init;
  logic                s2_valid;
  logic        [S-1:0] s2_sel;

  logic signed [P-1:0] op_a;
  logic signed [P-1:0] op_b;
  logic signed [A-1:0] prod_ext;
  logic signed [A-1:0] acc_sum;
  logic                hazard;
  logic                rd_fire;

  logic signed [A:0]   rd_ext;
  logic signed [A:0]   rd_rnd;
  logic signed [A:0]   rd_shift;
  logic                ovf_hi;
  logic                ovf_lo;
  logic        [W-1:0] fmt_data;

  assign in_ready = 1'b1;

  assign op_a     = P'(data_in_1);
  assign op_b     = P'(data_in_2);
  assign prod_ext = A'(s1_prod);
  assign acc_sum  = s1_init ? prod_ext : slot[s1_sel] + prod_ext;

  // The slot being written at the next edge, or just written, must not be read or cleared.
  assign hazard   = (s1_valid && (s1_sel == rd_sel)) || (s2_valid && (s2_sel == rd_sel));
  assign rd_ready = !hazard && !(out_valid && !out_ready);
  assign rd_fire  = rd_valid && rd_ready;

  assign rd_ext   = {slot[rd_sel][A-1], slot[rd_sel]};
  assign rd_rnd   = round_mode ? rd_ext + HALF_LSB : rd_ext;
  assign rd_shift = rd_rnd >>> FRAC_BITS;
  assign ovf_hi   = rd_shift > MAX_V;
  assign ovf_lo   = rd_shift < MIN_V;

  always_comb begin
    fmt_data = rd_shift[W-1:0];
    if (sat_en && ovf_hi) fmt_data = MAX_W;
    if (sat_en && ovf_lo) fmt_data = MIN_W;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_sel   <= '0;
      s1_init  <= 1'b0;
      s2_valid <= 1'b0;
      s2_sel   <= '0;
    end else begin
      s1_valid <= in_valid && in_ready;
      s1_prod  <= op_a * op_b;
      s1_sel   <= acc_sel;
      s1_init  <= acc_init;
      s2_valid <= s1_valid;
      s2_sel   <= s1_sel;
    end
  end

  // The interlock guarantees the stage-2 write and a clearing read never hit the same slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) slot[i] <= '0;
    end else begin
      if (s1_valid) slot[s1_sel] <= acc_sum;
      if (rd_fire && rd_clear) slot[rd_sel] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_ovf   <= 1'b0;
    end else if (rd_fire) begin
      out_valid <= 1'b1;
      data_out  <= fmt_data;
      out_ovf   <= ovf_hi || ovf_lo;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/pe_mac_bank.md
Name: pe_mac_bank

Overview:
Parametrised fixed-point processing element for the PE array. Each cycle it multiplies two signed Q(INT_BITS).(FRAC_BITS) operands and accumulates the product into one of NUM_ACC full-precision accumulator slots. A separate read port rounds and saturates a selected slot back to operand format. Both the MAC input and the result output use valid/ready handshakes, and read-after-accumulate hazards are interlocked in hardware.

Parameters:
INT_BITS, 7, integer bits of operand/result (incl. sign)
FRAC_BITS, 9, fractional bits of operand/result
NUM_ACC, 8, number of accumulator slots (>=2)
GUARD_BITS, 4, extra accumulator MSBs above full product width
Derived: W = INT_BITS+FRAC_BITS; P = 2W; A = P+GUARD_BITS; S = $clog2(NUM_ACC)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  MAC operand valid
in_ready  out  1  MAC operand accepted when in_valid&in_ready
data_in_1  in  W  signed operand A
data_in_2  in  W  signed operand B
acc_sel  in  S  target slot for this product
acc_init  in  1  1: slot := product (start new sum); 0: slot += product
rd_valid  in  1  read request
rd_ready  out  1  read accepted when rd_valid&rd_ready
rd_sel  in  S  slot to read
rd_clear  in  1  zero slot in the same cycle the read is accepted
round_mode  in  1  0 truncate toward -inf, 1 round half up; sampled with read
sat_en  in  1  1 saturate, 0 wrap; sampled with read
out_valid  out  1  data_out valid
out_ready  in  1  consumer accepts data_out
data_out  out  W  rounded result
out_ovf  out  1  result exceeded W range (set whether saturated or wrapped)

Behaviour:
- Reset (rst_n=0 at clock edge): all slots, pipeline regs, out_valid, data_out, out_ovf := 0. Reset mid-operation discards in-flight products and pending output.
- in_ready is constant 1 (MAC pipe never stalls).
- Stage 1 (accept edge t): register full signed product (P bits), acc_sel, acc_init, valid.
- Stage 2 (edge t+1): slot[sel] := sext(product) if acc_init, else slot[sel] + sext(product), A-bit two's-complement wrap. Slot value is visible from t+2. Back-to-back accumulates to the same slot are legal at 1/cycle, no bubbles.
- Hazard: rd_ready=0 if stage 1 or stage 2 holds a valid entry with sel==rd_sel. rd_ready=0 also if out_valid&!out_ready. Otherwise rd_ready=1.
- Read accepted at edge t: format slot[rd_sel] and load the output register. out_valid=1 from t+1 until the edge where out_valid&out_ready. Read accepted in the same cycle that out_ready drains the output is legal and gives a continuous stream.
- rd_clear: slot zeroed at acceptance edge. If a stage 2 write targets the same slot in the same edge, it cannot occur (interlock).
- Formatting: shift right by FRAC_BITS (arithmetic). round_mode=1 adds bit FRAC_BITS-1 before the shift. Range check against [-2^(W-1), 2^(W-1)-1].
  - out of range: out_ovf=1; data_out = saturated bound if sat_en, else low W bits.
- Product of two most-negative operands (-2^(W-1))^2 fits in P bits; no special case.
- data_out/out_ovf hold stable while out_valid&!out_ready.

Test Plan:
- Basic MAC: init slot 3 with 1.5*2.0 (0x0300*0x0400), read slot 3 at t+2 -> data_out 0x0600, out_ovf 0.
- Accumulate: 4 back-to-back products 0x0200*0x0200 into slot 0 (first acc_init=1), read -> 0x0800; same sequence with acc_init=1 on every entry -> 0x0200.
- Hazard: issue MAC to slot 5 and rd_valid on slot 5 the next cycle -> rd_ready low 2 cycles, read returns the updated value. Read of slot 6 in the same cycle -> rd_ready 1.
- Rounding: slot holding 0x00_0300 (0.75 LSB-weighted, 1.5 out LSB) -> truncate 0x0001, round_mode=1 0x0002. Negative -1.5 LSB -> truncate 0xFFFE, round 0xFFFF.
- Saturation: accumulate 63.0*63.0 -> sat_en=1 gives 0x7FFF, out_ovf=1; sat_en=0 gives wrapped low bits, out_ovf=1.
- Backpressure/reset: hold out_ready=0 -> data_out stable and rd_ready=0. Assert rst_n=0 with 2 products in flight -> all slots read 0, out_valid 0.
